// File: rtl/cpu_run_controller_if.sv
// ---------------------------------------------------------------------------
// cpu_run_controller_if
//   Bundles the host command pulses, the core status inputs and the run
//   controller outputs into one port group.
//
//   master : host/testbench side (drives commands and core status, observes
//            the controller outputs)
//   slave  : cpu_run_controller side
//
//   Command protocol: start/restart/stop/step are single-cycle pulses sampled
//   on the rising clock edge. There is no ready/acknowledge; a pulse that
//   arrives in a state where the command has no meaning is dropped, never
//   queued. Progress is observed through state/halted/halt_cause.
// ---------------------------------------------------------------------------
interface cpu_run_controller_if #(
  parameter int PC_WIDTH  = 64,
  parameter int CNT_WIDTH = 32
);
  // host commands
  logic                 start;
  logic                 restart;
  logic                 stop;
  logic                 step;
  // debug configuration
  logic                 bp_enable;
  logic [PC_WIDTH-1:0]  bp_addr;
  logic                 halt_on_dbz;
  // core status
  logic [PC_WIDTH-1:0]  pc;
  logic [31:0]          instr;
  logic                 divide_by_zero_flag;
  // controller outputs
  logic                 cpu_enable;
  logic                 cpu_reset;
  logic [2:0]           state;
  logic                 halted;
  logic [2:0]           halt_cause;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    output start, restart, stop, step, bp_enable, bp_addr, halt_on_dbz,
           pc, instr, divide_by_zero_flag,
    input  cpu_enable, cpu_reset, state, halted, halt_cause, instr_count
  );

  modport slave (
    input  start, restart, stop, step, bp_enable, bp_addr, halt_on_dbz,
           pc, instr, divide_by_zero_flag,
    output cpu_enable, cpu_reset, state, halted, halt_cause, instr_count
  );
endinterface

// File: rtl/cpu_run_controller.sv
// ---------------------------------------------------------------------------
// cpu_run_controller
//   Run/debug sequencer for the single-cycle RISC-V core. Holds the core in
//   reset for RST_CYCLES, free-runs it, single-steps it and halts it on a
//   stop command, PC breakpoint, EBREAK, divide-by-zero or instruction limit.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset of this block
//   bus    : cpu_run_controller_if.slave
//            in : start, restart, stop, step, bp_enable, bp_addr,
//                 halt_on_dbz, pc, instr, divide_by_zero_flag
//            out: cpu_enable (combinational), cpu_reset (registered),
//                 state (0 IDLE,1 CPURST,2 RUN,3 STEP,4 HALT), halted,
//                 halt_cause (0 none,1 stop,2 bp,3 ebreak,4 dbz,5 limit,
//                 6 step-done), instr_count (saturating)
// ---------------------------------------------------------------------------
module cpu_run_controller #(
  parameter int PC_WIDTH   = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 0
) (
  input logic                 clk,
  input logic                 reset,
  cpu_run_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CPURST = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_STOP  = 3'd1;
  localparam logic [2:0] CAUSE_BP    = 3'd2;
  localparam logic [2:0] CAUSE_EBRK  = 3'd3;
  localparam logic [2:0] CAUSE_DBZ   = 3'd4;
  localparam logic [2:0] CAUSE_LIMIT = 3'd5;
  localparam logic [2:0] CAUSE_STEP  = 3'd6;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int          RW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]        RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LIMIT    = CNT_WIDTH'(MAX_CYCLES);

  state_e               state_q, state_d;
  logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic [2:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 bp_skip_q, bp_skip_d;

  logic                 cpu_enable;
  logic                 halt_hit;
  logic [2:0]           hit_cause;
  logic                 enter_rst;

  // Halt conditions, highest priority first.
  always_comb begin
    halt_hit  = 1'b1;
    hit_cause = CAUSE_NONE;
    if (bus.stop)                                   hit_cause = CAUSE_STOP;
    else if (bus.halt_on_dbz && bus.divide_by_zero_flag) hit_cause = CAUSE_DBZ;
    else if (bus.instr == EBREAK)                   hit_cause = CAUSE_EBRK;
    else if (bus.bp_enable && (bus.pc == bus.bp_addr) && !bp_skip_q)
                                                    hit_cause = CAUSE_BP;
    else if ((MAX_CYCLES != 0) && (count_q == LIMIT)) hit_cause = CAUSE_LIMIT;
    else                                            halt_hit  = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    cause_d    = cause_q;
    count_d    = count_q;
    bp_skip_d  = bp_skip_q;
    cpu_enable = 1'b0;
    enter_rst  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) enter_rst = 1'b1;
      end
      ST_CPURST: begin
        if (bus.restart)               enter_rst = 1'b1;
        else if (rst_cnt_q == RST_LAST) state_d  = ST_RUN;
        else                           rst_cnt_d = rst_cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (bus.restart) begin
          enter_rst = 1'b1;
        end else if (halt_hit) begin
          state_d = ST_HALT;
          cause_d = hit_cause;
        end else begin
          cpu_enable = 1'b1;
          bp_skip_d  = 1'b0;
        end
      end
      ST_STEP: begin
        if (bus.restart) begin
          enter_rst = 1'b1;
        end else begin
          cpu_enable = 1'b1;
          state_d    = ST_HALT;
          cause_d    = CAUSE_STEP;
        end
      end
      ST_HALT: begin
        if (bus.restart) begin
          enter_rst = 1'b1;
        end else if (bus.start) begin
          // Let a resume at the breakpoint PC execute that instruction once.
          state_d   = ST_RUN;
          bp_skip_d = 1'b1;
        end else if (bus.step) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_rst) begin
      state_d   = ST_CPURST;
      rst_cnt_d = '0;
      count_d   = '0;
      cause_d   = CAUSE_NONE;
      bp_skip_d = 1'b0;
    end

    if (cpu_enable && (count_q != '1)) count_d = count_q + 1'b1;

    // Core reset follows the next state so it drops on the edge into RUN.
    cpu_reset_d = (state_d == ST_IDLE) || (state_d == ST_CPURST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      cpu_reset_q <= 1'b1;
      cause_q     <= CAUSE_NONE;
      count_q     <= '0;
      bp_skip_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cpu_reset_q <= cpu_reset_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      bp_skip_q   <= bp_skip_d;
    end
  end

  assign bus.cpu_enable  = cpu_enable;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.halt_cause  = cause_q;
  assign bus.instr_count = count_q;

endmodule
